// File: rtl/ptw_arb_pkg.sv
// ---------------------------------------------------------------------------
// ptw_arb_pkg
// Shared definitions for the ITLB/DTLB page-table-walker arbiter:
//   - state_e   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   - PORT_*    : requester port ids (ITLB = 0, DTLB = 1)
//   - VPN_*     : virtual page number field bounds used for same-page merging
//   - ADDR_W / PTE_W : address and PTE widths
// ---------------------------------------------------------------------------
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic PORT_ITLB = 1'b0;
  localparam logic PORT_DTLB = 1'b1;

  localparam int VPN_MSB = 31;
  localparam int VPN_LSB = 12;

  localparam int ADDR_W = 32;
  localparam int PTE_W  = 32;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant with a single priority pointer bit.
// Purely combinational; the caller owns the pointer register.
//   req_i     [1:0] in  : request vector (bit 0 = ITLB, bit 1 = DTLB)
//   ptr_i           in  : favoured port id when both request
//   gnt_o     [1:0] out : one-hot grant (zero when no request)
//   ptr_nxt_o       out : pointer value to load if the grant is taken;
//                         after granting port k it favours the other port
// ---------------------------------------------------------------------------
module rr_arb2
  import ptw_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_nxt_o
);

  always_comb begin
    gnt_o     = 2'b00;
    ptr_nxt_o = ptr_i;
    unique case (req_i)
      2'b01: begin
        gnt_o     = 2'b01;
        ptr_nxt_o = ~PORT_ITLB;
      end
      2'b10: begin
        gnt_o     = 2'b10;
        ptr_nxt_o = ~PORT_DTLB;
      end
      2'b11: begin
        if (ptr_i == PORT_ITLB) begin
          gnt_o     = 2'b01;
          ptr_nxt_o = ~PORT_ITLB;
        end else begin
          gnt_o     = 2'b10;
          ptr_nxt_o = ~PORT_DTLB;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ptw_arb.sv
// ---------------------------------------------------------------------------
// ptw_arb
// Arbitrates ITLB (port 0) and DTLB (port 1) miss requests onto a single
// page-table walker, one walk outstanding at a time, and routes the returned
// PTE back to every port that is waiting on that walk.
//
// Ports
//   clk, rst_n                      : clock, synchronous active-low reset
//   itlb_req_valid_i/ready_o/vaddr_i: port 0 miss request
//   itlb_resp_valid_o/ready_i/pte_o : port 0 PTE response
//   dtlb_*                          : same for port 1
//   ptw_req_valid_o/ready_i/vaddr_o : request to the walker
//   ptw_resp_valid_i/ready_o/pte_i  : walker PTE (0 = invalid, passed through)
//
// Configuration
//   PTW_ARB_MERGE_EN : when defined, simultaneous ITLB/DTLB requests to the
//                      same virtual page share one walk (ITLB address) and
//                      leave the round-robin pointer unchanged.
// ---------------------------------------------------------------------------
module ptw_arb
  import ptw_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              itlb_req_valid_i,
  output logic              itlb_req_ready_o,
  input  logic [ADDR_W-1:0] itlb_vaddr_i,
  output logic              itlb_resp_valid_o,
  input  logic              itlb_resp_ready_i,
  output logic [PTE_W-1:0]  itlb_pte_o,

  input  logic              dtlb_req_valid_i,
  output logic              dtlb_req_ready_o,
  input  logic [ADDR_W-1:0] dtlb_vaddr_i,
  output logic              dtlb_resp_valid_o,
  input  logic              dtlb_resp_ready_i,
  output logic [PTE_W-1:0]  dtlb_pte_o,

  output logic              ptw_req_valid_o,
  input  logic              ptw_req_ready_i,
  output logic [ADDR_W-1:0] ptw_vaddr_o,
  input  logic              ptw_resp_valid_i,
  output logic              ptw_resp_ready_o,
  input  logic [PTE_W-1:0]  ptw_pte_i
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [PTE_W-1:0]  pte_q, pte_d;

  logic [1:0]        req_vld;
  logic [1:0]        arb_gnt;
  logic              arb_ptr_nxt;
  logic [1:0]        gnt;
  logic              gnt_ptr;

  logic [1:0]        req_rdy;
  logic [1:0]        resp_vld;
  logic [1:0]        resp_rdy;
  logic              walk_vld;
  logic              walk_rdy;

  assign req_vld  = {dtlb_req_valid_i, itlb_req_valid_i};
  assign resp_rdy = {dtlb_resp_ready_i, itlb_resp_ready_i};

  rr_arb2 u_rr_arb2 (
    .req_i     (req_vld),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .ptr_nxt_o (arb_ptr_nxt)
  );

`ifdef PTW_ARB_MERGE_EN
  // Same-page requests ride on one walk; pointer is left alone so neither
  // port loses its turn because of a shared walk.
  logic merge;
  assign merge   = (&req_vld) &&
                   (itlb_vaddr_i[VPN_MSB:VPN_LSB] == dtlb_vaddr_i[VPN_MSB:VPN_LSB]);
  assign gnt     = merge ? 2'b11 : arb_gnt;
  assign gnt_ptr = merge ? ptr_q : arb_ptr_nxt;
`else
  assign gnt     = arb_gnt;
  assign gnt_ptr = arb_ptr_nxt;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q;
    vaddr_d  = vaddr_q;
    pte_d    = pte_q;
    req_rdy  = 2'b00;
    resp_vld = 2'b00;
    walk_vld = 1'b0;
    walk_rdy = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only the valids seen this cycle take part; a port that drops
        // valid here is simply not in req_vld.
        if (|req_vld) begin
          req_rdy = gnt;
          pend_d  = gnt;
          ptr_d   = gnt_ptr;
          vaddr_d = gnt[0] ? itlb_vaddr_i : dtlb_vaddr_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        walk_vld = 1'b1;
        if (ptw_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        walk_rdy = 1'b1;
        if (ptw_resp_valid_i) begin
          pte_d   = ptw_pte_i;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_vld = pend_q;
        pend_d   = pend_q & ~resp_rdy;
        if (pend_d == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PORT_ITLB;
      pend_q  <= 2'b00;
      vaddr_q <= '0;
      pte_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      vaddr_q <= vaddr_d;
      pte_q   <= pte_d;
    end
  end

  // Outputs are forced low while reset is held so that requesters holding
  // valid during reset never see a ready.
  assign itlb_req_ready_o  = rst_n & req_rdy[0];
  assign dtlb_req_ready_o  = rst_n & req_rdy[1];
  assign itlb_resp_valid_o = rst_n & resp_vld[0];
  assign dtlb_resp_valid_o = rst_n & resp_vld[1];
  assign itlb_pte_o        = (rst_n && resp_vld[0]) ? pte_q : '0;
  assign dtlb_pte_o        = (rst_n && resp_vld[1]) ? pte_q : '0;
  assign ptw_req_valid_o   = rst_n & walk_vld;
  assign ptw_vaddr_o       = (rst_n && walk_vld) ? vaddr_q : '0;
  assign ptw_resp_ready_o  = rst_n & walk_rdy;

endmodule

// File: tb/tb_ptw_arb.sv
// ---------------------------------------------------------------------------
// tb_ptw_arb
// Bench for ptw_arb. Requesters and a walker model are driven from queues;
// a monitor at the falling edge predicts grants and responses from a
// transaction-level model (favoured port, walks outstanding, per-port
// expected PTE queues) and compares DUT outputs against it.
// Honours PTW_ARB_MERGE_EN for the merge expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ptw_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        itlb_req_valid_i = 1'b0, itlb_req_ready_o;
  logic [31:0] itlb_vaddr_i = '0;
  logic        itlb_resp_valid_o, itlb_resp_ready_i = 1'b0;
  logic [31:0] itlb_pte_o;
  logic        dtlb_req_valid_i = 1'b0, dtlb_req_ready_o;
  logic [31:0] dtlb_vaddr_i = '0;
  logic        dtlb_resp_valid_o, dtlb_resp_ready_i = 1'b0;
  logic [31:0] dtlb_pte_o;
  logic        ptw_req_valid_o, ptw_req_ready_i = 1'b0;
  logic [31:0] ptw_vaddr_o;
  logic        ptw_resp_valid_i = 1'b0, ptw_resp_ready_o;
  logic [31:0] ptw_pte_i = '0;

  always #5 clk = ~clk;

  ptw_arb dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .itlb_req_valid_i  (itlb_req_valid_i),
    .itlb_req_ready_o  (itlb_req_ready_o),
    .itlb_vaddr_i      (itlb_vaddr_i),
    .itlb_resp_valid_o (itlb_resp_valid_o),
    .itlb_resp_ready_i (itlb_resp_ready_i),
    .itlb_pte_o        (itlb_pte_o),
    .dtlb_req_valid_i  (dtlb_req_valid_i),
    .dtlb_req_ready_o  (dtlb_req_ready_o),
    .dtlb_vaddr_i      (dtlb_vaddr_i),
    .dtlb_resp_valid_o (dtlb_resp_valid_o),
    .dtlb_resp_ready_i (dtlb_resp_ready_i),
    .dtlb_pte_o        (dtlb_pte_o),
    .ptw_req_valid_o   (ptw_req_valid_o),
    .ptw_req_ready_i   (ptw_req_ready_i),
    .ptw_vaddr_o       (ptw_vaddr_o),
    .ptw_resp_valid_i  (ptw_resp_valid_i),
    .ptw_resp_ready_o  (ptw_resp_ready_o),
    .ptw_pte_i         (ptw_pte_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Page table contents the walker model returns (VPN 3 maps to invalid 0).
  function automatic logic [31:0] ref_pte(input logic [31:0] va);
    logic [19:0] vpn;
    vpn = va[31:12];
    case (vpn)
      20'd0:   ref_pte = 32'h1000_000F;
      20'd1:   ref_pte = 32'h1100_000F;
      20'd2:   ref_pte = 32'h1200_0007;
      20'd3:   ref_pte = 32'h0000_0000;
      default: ref_pte = {vpn ^ 20'h5A5A5, 12'h0C7};
    endcase
  endfunction

  // Stimulus queues and knobs
  logic [31:0] dq0[$], dq1[$];
  int   w_delay = 0;
  logic w_delay_rand = 1'b0, w_blk = 1'b0, w_rand = 1'b0;
  logic rr_blk0 = 1'b0, rr_blk1 = 1'b0, rr_rand = 1'b0, drop_en = 1'b0;

  // Reference model state
  logic        m_fav = 1'b0;
  int          m_out = 0;
  logic        m_wait = 1'b0, m_ret = 1'b0;
  logic [31:0] wq[$], eq0[$], eq1[$];
  logic        acc_i = 1'b0, acc_d = 1'b0, hs_req = 1'b0, hs_resp = 1'b0;
  logic [31:0] hs_vaddr = '0;
  int          n_walks = 0, n_resp0 = 0, n_resp1 = 0;
  logic [31:0] last_pte0 = '0, last_pte1 = '0;
  int          gl[$];
  logic [1:0]  eg, vld;
  logic        r0, r1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl_outputs", {26'd0, itlb_req_ready_o, dtlb_req_ready_o, itlb_resp_valid_o,
                              dtlb_resp_valid_o, ptw_req_valid_o, ptw_resp_ready_o}, 32'd0);
      chk("rst_data_outputs", ptw_vaddr_o | itlb_pte_o | dtlb_pte_o, 32'd0);
      m_fav = 1'b0; m_out = 0; m_wait = 1'b0; m_ret = 1'b0;
      wq.delete(); eq0.delete(); eq1.delete();
      acc_i = 1'b0; acc_d = 1'b0; hs_req = 1'b0; hs_resp = 1'b0;
    end else begin
      chk("ptw_req_valid", ptw_req_valid_o, wq.size() != 0);
      if (ptw_req_valid_o && wq.size() != 0) chk("ptw_vaddr", ptw_vaddr_o, wq[0]);
      else                                   chk("ptw_vaddr_idle", ptw_vaddr_o, 32'd0);
      hs_req = ptw_req_valid_o && ptw_req_ready_i && (wq.size() != 0);

      chk("ptw_resp_ready", ptw_resp_ready_o, m_wait);
      hs_resp = m_wait && ptw_resp_valid_i;

      chk("itlb_resp_valid", itlb_resp_valid_o, m_ret && eq0.size() != 0);
      if (itlb_resp_valid_o && eq0.size() != 0) chk("itlb_pte", itlb_pte_o, eq0[0]);
      else                                      chk("itlb_pte_idle", itlb_pte_o, 32'd0);
      chk("dtlb_resp_valid", dtlb_resp_valid_o, m_ret && eq1.size() != 0);
      if (dtlb_resp_valid_o && eq1.size() != 0) chk("dtlb_pte", dtlb_pte_o, eq1[0]);
      else                                      chk("dtlb_pte_idle", dtlb_pte_o, 32'd0);
      r0 = m_ret && eq0.size() != 0 && itlb_resp_ready_i;
      r1 = m_ret && eq1.size() != 0 && dtlb_resp_ready_i;
      if (itlb_resp_valid_o && itlb_resp_ready_i) begin n_resp0++; last_pte0 = itlb_pte_o; end
      if (dtlb_resp_valid_o && dtlb_resp_ready_i) begin n_resp1++; last_pte1 = dtlb_pte_o; end

      eg = 2'b00;
      if (m_out == 0) begin
        vld = {dtlb_req_valid_i, itlb_req_valid_i};
        if (vld == 2'b11) begin
`ifdef PTW_ARB_MERGE_EN
          if (itlb_vaddr_i[31:12] == dtlb_vaddr_i[31:12]) eg = 2'b11;
          else
`endif
          eg = m_fav ? 2'b10 : 2'b01;
        end else begin
          eg = vld;
        end
      end
      chk("itlb_req_ready", itlb_req_ready_o, eg[0]);
      chk("dtlb_req_ready", dtlb_req_ready_o, eg[1]);

      if (hs_req) begin
        hs_vaddr = wq.pop_front();
        m_wait = 1'b1;
        n_walks++;
      end
      if (hs_resp) begin
        m_wait = 1'b0;
        m_ret = 1'b1;
      end
      if (r0) begin void'(eq0.pop_front()); m_out--; end
      if (r1) begin void'(eq1.pop_front()); m_out--; end
      if ((r0 || r1) && m_out == 0) m_ret = 1'b0;

      if (eg == 2'b11) begin
        wq.push_back(itlb_vaddr_i);
        eq0.push_back(ref_pte(itlb_vaddr_i));
        eq1.push_back(ref_pte(itlb_vaddr_i));
        m_out = 2;
        gl.push_back(2);
      end else if (eg[0]) begin
        wq.push_back(itlb_vaddr_i);
        eq0.push_back(ref_pte(itlb_vaddr_i));
        m_out = 1; m_fav = 1'b1;
        gl.push_back(0);
      end else if (eg[1]) begin
        wq.push_back(dtlb_vaddr_i);
        eq1.push_back(ref_pte(dtlb_vaddr_i));
        m_out = 1; m_fav = 1'b0;
        gl.push_back(1);
      end
      acc_i = eg[0];
      acc_d = eg[1];
    end
  end

  // Requester and walker drivers
  logic        w_pend = 1'b0;
  int          w_cnt = 0;
  logic [31:0] w_pte = '0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (acc_i && dq0.size() != 0) void'(dq0.pop_front());
      if (acc_d && dq1.size() != 0) void'(dq1.pop_front());
      if (hs_resp) begin ptw_resp_valid_i = 1'b0; ptw_pte_i = '0; end
      if (hs_req) begin
        w_pend = 1'b1;
        w_cnt  = w_delay_rand ? int'($urandom_range(0, w_delay)) : w_delay;
        w_pte  = ref_pte(hs_vaddr);
      end
      if (w_pend) begin
        if (w_cnt == 0) begin
          ptw_resp_valid_i = 1'b1; ptw_pte_i = w_pte; w_pend = 1'b0;
        end else begin
          w_cnt--;
        end
      end
    end else begin
      w_pend = 1'b0; ptw_resp_valid_i = 1'b0; ptw_pte_i = '0;
    end
    if (dq0.size() != 0 && !(drop_en && $urandom_range(0, 7) == 0)) begin
      itlb_req_valid_i = 1'b1; itlb_vaddr_i = dq0[0];
    end else begin
      itlb_req_valid_i = 1'b0; itlb_vaddr_i = $urandom;
    end
    if (dq1.size() != 0 && !(drop_en && $urandom_range(0, 7) == 0)) begin
      dtlb_req_valid_i = 1'b1; dtlb_vaddr_i = dq1[0];
    end else begin
      dtlb_req_valid_i = 1'b0; dtlb_vaddr_i = $urandom;
    end
    itlb_resp_ready_i = rr_blk0 ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    dtlb_resp_ready_i = rr_blk1 ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    ptw_req_ready_i   = !rst_n ? 1'b0 : w_blk ? 1'b0 :
                        (w_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  task automatic wait_idle(input string name, input int maxc);
    int c;
    c = 0;
    while ((dq0.size() != 0 || dq1.size() != 0 || m_out != 0) && c < maxc) begin
      @(posedge clk);
      c++;
    end
    chk({name, "_complete"}, c < maxc, 1'b1);
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int n0, b0, b1, c, lat;
  logic [19:0] rvpn;

  initial begin
    // Reset with both requesters already asserting
    rst_n = 1'b0;
    dq0.push_back(32'h0000_4000);
    dq1.push_back(32'h0000_5000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_itlb", itlb_req_ready_o, 1'b1);
    chk("first_grant_not_dtlb", dtlb_req_ready_o, 1'b0);
    wait_idle("reset_phase", 200);

    // Single DTLB request
    w_delay = 2;
    b0 = n_resp0; b1 = n_resp1;
    dq1.push_back(32'h0000_1000);
    wait_idle("single", 200);
    chk("single_itlb_resp_count", n_resp0 - b0, 0);
    chk("single_dtlb_resp_count", n_resp1 - b1, 1);
    chk("single_dtlb_pte", last_pte1, 32'h1100_000F);

    // Continuous contention
    w_delay = 0;
    gl.delete();
    dq0.push_back(32'h0000_0000); dq0.push_back(32'h0000_0000);
    dq1.push_back(32'h0000_2000); dq1.push_back(32'h0000_2000);
    wait_idle("contention", 400);
    chk("contention_grants", gl.size(), 4);
    for (int i = 0; i < gl.size() && i < 4; i++) chk("contention_order", gl[i], i % 2);
    chk("contention_itlb_pte", last_pte0, 32'h1000_000F);
    chk("contention_dtlb_pte", last_pte1, 32'h1200_0007);

    // Walker and response backpressure
    w_delay = 1;
    n0 = n_walks;
    w_blk = 1'b1; rr_blk0 = 1'b1;
    dq0.push_back(32'h0000_1234);
    repeat (6) @(negedge clk);
    chk("bp_walk_held", ptw_req_valid_o, 1'b1);
    @(posedge clk); #2;
    w_blk = 1'b0;
    dq1.push_back(32'h0000_3000);
    c = 0;
    do begin @(negedge clk); c++; end while (!itlb_resp_valid_o && c < 50);
    chk("bp_resp_seen", c < 50, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_pte_hold", itlb_pte_o, 32'h1100_000F);
      chk("bp_no_second_walk", ptw_req_valid_o, 1'b0);
    end
    @(posedge clk); #2 rr_blk0 = 1'b0;
    wait_idle("backpressure", 200);
    chk("bp_walk_count", n_walks - n0, 2);
    chk("bp_invalid_pte_passthrough", last_pte1, 32'h0000_0000);

    // Same-page requests in the same cycle
    n0 = n_walks; gl.delete();
    dq0.push_back(32'h0000_0000);
    dq1.push_back(32'h0000_0800);
    wait_idle("merge", 200);
`ifdef PTW_ARB_MERGE_EN
    chk("merge_walk_count", n_walks - n0, 1);
    chk("merge_grant", gl.size() > 0 ? gl[0] : -1, 2);
`else
    chk("nomerge_walk_count", n_walks - n0, 2);
    chk("nomerge_first", gl.size() > 0 ? gl[0] : -1, 0);
    chk("nomerge_second", gl.size() > 1 ? gl[1] : -1, 1);
`endif
    chk("merge_itlb_pte", last_pte0, 32'h1000_000F);
    chk("merge_dtlb_pte", last_pte1, 32'h1000_000F);

    // Reset while the walker is busy
    w_delay = 30;
    b0 = n_resp0; b1 = n_resp1;
    dq0.push_back(32'h0000_2000);
    c = 0;
    do begin @(negedge clk); c++; end while (!ptw_resp_ready_o && c < 40);
    chk("mwr_reached_wait", ptw_resp_ready_o, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0; dq0.delete(); dq1.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    w_delay = 0;
    repeat (5) begin
      @(negedge clk);
      chk("mwr_no_resp", {31'd0, itlb_resp_valid_o | dtlb_resp_valid_o}, 32'd0);
    end
    @(posedge clk); #2;
    dq1.push_back(32'h0000_2000);
    c = 0;
    do begin @(negedge clk); c++; end while (!dtlb_req_ready_o && c < 20);
    chk("mwr_accept", dtlb_req_ready_o, 1'b1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dtlb_resp_valid_o && lat < 20);
    chk("mwr_min_latency", lat, 3);
    wait_idle("mid_walk_reset", 200);
    chk("mwr_itlb_resp_count", n_resp0 - b0, 0);
    chk("mwr_dtlb_resp_count", n_resp1 - b1, 1);
    chk("mwr_dtlb_pte", last_pte1, 32'h1200_0007);

    // Randomized traffic
    w_delay = 3; w_delay_rand = 1'b1; w_rand = 1'b1; rr_rand = 1'b1; drop_en = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #2;
      if (dq0.size() < 3 && $urandom_range(0, 3) == 0) begin
        rvpn = 20'($urandom_range(0, 5));
        dq0.push_back({rvpn, 12'($urandom)});
      end
      if (dq1.size() < 3 && $urandom_range(0, 3) == 0) begin
        rvpn = 20'($urandom_range(0, 5));
        dq1.push_back({rvpn, 12'($urandom)});
      end
    end
    drop_en = 1'b0;
    wait_idle("random", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ptw_arb.md
PTW_ARB -- requirements
Module: ptw_arb

Interface
REQ-001 The block SHALL have these ports, one clock domain, with ports listed as name, direction, width and meaning.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- itlb_req_valid_i  in  1  ITLB miss request (port 0)
- itlb_req_ready_o  out  1  port 0 request accepted
- itlb_vaddr_i  in  32  port 0 virtual address
- itlb_resp_valid_o  out  1  port 0 PTE response valid
- itlb_resp_ready_i  in  1  port 0 response accepted
- itlb_pte_o  out  32  port 0 returned PTE
- dtlb_req_valid_i, dtlb_req_ready_o, dtlb_vaddr_i, dtlb_resp_valid_o, dtlb_resp_ready_i, dtlb_pte_o  same widths and meanings, port 1
- ptw_req_valid_o  out  1  request to the page-table walker
- ptw_req_ready_i  in  1  walker accepts request
- ptw_vaddr_o  out  32  address sent to the walker
- ptw_resp_valid_i  in  1  walker PTE valid
- ptw_resp_ready_o  out  1  arbiter accepts walker PTE
- ptw_pte_i  in  32  walker PTE; 0x00000000 means invalid, passed through unmodified

Function
REQ-002 The FSM SHALL have exactly four states:
- IDLE -> ISSUE on any request valid.
- ISSUE -> WAIT when ptw_req_valid_o && ptw_req_ready_i.
- WAIT -> RESP when ptw_resp_valid_i.
- RESP -> IDLE when every pending port has handshaked.
REQ-003 In IDLE with at least one *_req_valid_i high, the block SHALL:
- pick a winner;
- assert that port's *_req_ready_o for exactly that cycle;
- latch the winner's vaddr and port id.
REQ-004 *_req_ready_o SHALL be 0 in every state other than IDLE.
REQ-005 Round-robin: one priority pointer bit; reset value 0 (ITLB favoured).
- On a single grant to port k the pointer becomes ~k.
- A lone requester always wins, regardless of the pointer.
REQ-006 In ISSUE, ptw_req_valid_o SHALL be 1 and ptw_vaddr_o SHALL equal the latched vaddr, held stable until the handshake; ptw_req_valid_o SHALL be 0 in all other states.
REQ-007 In WAIT, ptw_resp_ready_o SHALL be 1; the PTE SHALL be latched on ptw_resp_valid_i; ptw_resp_ready_o SHALL be 0 in all other states.
REQ-008 In RESP, resp_valid_o of each pending port SHALL be 1 with *_pte_o equal to the latched PTE.
- Each port's valid drops on its own resp handshake.
- Responses SHALL never go to a non-pending port.
REQ-009 Only one walk SHALL be outstanding at a time.
- Minimum latency, request accept to resp_valid_o: 3 cycles with zero walker delay (IDLE, ISSUE, WAIT, then RESP).
REQ-010 ptw_vaddr_o SHALL be 0 when not in ISSUE; *_pte_o SHALL be 0 when that port's resp_valid_o is 0.
REQ-011 A requester dropping valid in the same cycle it would win SHALL NOT be granted; arbitration uses only the valids sampled in that IDLE cycle.

Reset
REQ-012 When rst_n is 0 at a clock edge, the block SHALL:
- enter IDLE;
- clear the pointer, pending bits, latched vaddr and latched PTE;
- drive all outputs 0.
REQ-013 Reset mid-walk SHALL abandon the transaction without issuing a response; the walker is reset by the same rst_n.

Configuration
REQ-014 The merge feature is controlled by the macro PTW_ARB_MERGE_EN.
- Defined: in IDLE, if both valids are high and itlb_vaddr_i[31:12] == dtlb_vaddr_i[31:12], both ready_o SHALL assert, one walk (the ITLB vaddr) SHALL be issued, both ports SHALL be pending, and the pointer SHALL be unchanged.
- Undefined: same-page requests SHALL be arbitrated normally per REQ-005, and the merge logic SHALL be absent.

Structure
REQ-015 A shared package SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the port-id constants (ITLB=0, DTLB=1), and the VPN field bounds (31:12).
REQ-016 One sub-module, rr_arb2 (a 2-requester round-robin grant plus pointer update), SHALL be instantiated; everything else is in ptw_arb.

Verification
REQ-017 Reset: hold rst_n=0 for 2 cycles with both valids high -> all ready/valid outputs are 0; after release the first grant goes to ITLB.
REQ-018 Single port: DTLB requests 0x00001000, walker returns 0x1100000F -> dtlb_resp_valid_o with dtlb_pte_o=0x1100000F; ITLB resp_valid stays 0.
REQ-019 Contention: both ports request continuously with 0x00000000 and 0x00002000 -> grants alternate ITLB, DTLB, ITLB, DTLB; each port gets its own PTE (0x1000000F, 0x12000007).
REQ-020 Backpressure: ptw_req_ready_i held low for 5 cycles, then ITLB resp_ready_i held low for 4 cycles -> ptw_vaddr_o stays stable; PTE is held; no second walk is issued.
REQ-021 Merge (PTW_ARB_MERGE_EN defined): ITLB 0x00000000 and DTLB 0x00000800 in the same cycle -> one walk, both receive 0x1000000F; without the macro -> two walks in ITLB-then-DTLB order.
REQ-022 Mid-walk reset: rst_n=0 while in WAIT -> no resp_valid_o is asserted, the block is back in IDLE, and the next request completes normally.
